// File: rtl/ddr2_rst_sequencer_pkg.sv
// Shared state encodings, default parameters and sizing helper for the
// DDR2 reset sequencer.
package ddr2_rst_seq_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_LOCK = 3'd0,
    ST_HOLD      = 3'd1,
    ST_WAIT_RDY  = 3'd2,
    ST_RELEASE   = 3'd3,
    ST_RUN       = 3'd4,
    ST_FAULT     = 3'd5
  } seq_state_t;

  localparam int DEF_NUM_CH      = 4;
  localparam int DEF_HOLD_CYCLES = 25;
  localparam int DEF_STAGGER     = 16;
  localparam int DEF_RDY_TIMEOUT = 4096;
  localparam int DEF_SYNC_STAGES = 2;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/ddr2_sync_bit.sv
// Multi-flop synchroniser bringing a single asynchronous level into clk200.
module ddr2_sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk200,
  input  logic rst200,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk200) begin
    if (rst200) sync_q <= '0;
    else        sync_q <= {sync_q[STAGES-2:0], d};
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/ddr2_rst_sequencer.sv
// Power-up reset sequencer: waits for clock lock, holds the IDELAY controller
// in reset, then releases channel resets one by one.
//
// state      | meaning
// WAIT_LOCK  | everything in reset, waiting for synchronised lock
// HOLD       | lock seen, IDELAY controller reset held HOLD_CYCLES
// WAIT_RDY   | controller released, waiting for ctrl_rdy (bounded)
// RELEASE    | channel resets falling every STAGGER cycles, ascending
// RUN        | all channels out of reset
// FAULT      | ctrl_rdy timeout; only retry or rst200 leaves
module ddr2_rst_sequencer
  import ddr2_rst_seq_pkg::*;
#(
  parameter int NUM_CH      = DEF_NUM_CH,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int STAGGER     = DEF_STAGGER,
  parameter int RDY_TIMEOUT = DEF_RDY_TIMEOUT,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic              clk200,
  input  logic              rst200,
  input  logic              clk_lock,
  input  logic              ctrl_rdy,
  input  logic              retry,
  output logic              ctrl_rst,
  output logic [NUM_CH-1:0] ch_rst,
  output logic              all_ready,
  output logic              fault,
  output logic [2:0]        state_o
);

  localparam int CW = $clog2(max3(HOLD_CYCLES, STAGGER * NUM_CH, RDY_TIMEOUT)) + 1;
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
  localparam logic [CW-1:0] HOLD_END = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] RDY_END  = CW'(RDY_TIMEOUT - 1);
  localparam logic [CW-1:0] REL_END  = CW'((NUM_CH - 1) * STAGGER);

  logic              lock_s;
  seq_state_t        state, state_nx;
  logic [CW-1:0]     cnt, cnt_nx;
  logic              ctrl_rst_nx, all_ready_nx, fault_nx;
  logic [NUM_CH-1:0] ch_rst_nx;

  ddr2_sync_bit #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .clk200 (clk200),
    .rst200 (rst200),
    .d      (clk_lock),
    .q      (lock_s)
  );

  always_comb begin
    state_nx = state;
    cnt_nx   = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);

    if (state != ST_FAULT && !lock_s) begin
      state_nx = ST_WAIT_LOCK;
    end else if ((state == ST_RELEASE || state == ST_RUN) && !ctrl_rdy) begin
      state_nx = ST_WAIT_LOCK;
    end else begin
      case (state)
        ST_WAIT_LOCK: if (lock_s) state_nx = ST_HOLD;
        ST_HOLD:      if (cnt == HOLD_END) state_nx = ST_WAIT_RDY;
        ST_WAIT_RDY: begin
          if (ctrl_rdy)             state_nx = ST_RELEASE;
          else if (cnt == RDY_END)  state_nx = ST_FAULT;
        end
        ST_RELEASE:   if (cnt == REL_END) state_nx = ST_RUN;
        ST_RUN:       state_nx = ST_RUN;
        ST_FAULT:     if (retry) state_nx = ST_WAIT_LOCK;
        default:      state_nx = ST_WAIT_LOCK;
      endcase
    end

    if (state_nx != state) cnt_nx = '0;

    // Outputs are decoded from the next state so they register alongside it.
    ctrl_rst_nx  = (state_nx == ST_WAIT_LOCK) || (state_nx == ST_HOLD) ||
                   (state_nx == ST_FAULT);
    all_ready_nx = (state_nx == ST_RUN);
    fault_nx     = (state_nx == ST_FAULT);
    ch_rst_nx    = '1;
    if (state_nx == ST_RUN) begin
      ch_rst_nx = '0;
    end else if (state_nx == ST_RELEASE) begin
      for (int k = 0; k < NUM_CH; k++)
        ch_rst_nx[k] = (cnt_nx < CW'(k * STAGGER));
    end
  end

  always_ff @(posedge clk200) begin
    if (rst200) begin
      state     <= ST_WAIT_LOCK;
      cnt       <= '0;
      ctrl_rst  <= 1'b1;
      ch_rst    <= '1;
      all_ready <= 1'b0;
      fault     <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      ctrl_rst  <= ctrl_rst_nx;
      ch_rst    <= ch_rst_nx;
      all_ready <= all_ready_nx;
      fault     <= fault_nx;
    end
  end

  assign state_o = state;

endmodule
